// File: rtl/dmem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl_if
//  Description : Request/response and data-memory signal bundle for the
//                load/store controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic        mem_WE;
    logic        mem_writebyte;
    logic        mem_writehalfword;
    logic [31:0] mem_data;

    // The CPU datapath and the memory together form the environment (master).
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_data,
        input  req_ready, resp_valid, resp_fault, resp_rdata,
        input  mem_address, mem_datain, mem_WE, mem_writebyte, mem_writehalfword
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_data,
        output req_ready, resp_valid, resp_fault, resp_rdata,
        output mem_address, mem_datain, mem_WE, mem_writebyte, mem_writehalfword
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Single-outstanding load/store controller for a big-endian,
//                async-read data memory with alignment and range checking.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl #(
    parameter logic [31:0] STARTADDR = 32'h1000_0000,
    parameter logic [31:0] LENGTH    = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    dmem_access_ctrl_if.slave bus
);
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_ACCESS = 2'd1;
    localparam logic [1:0]  S_RESP   = 2'd2;

    localparam logic [32:0] c_first = {1'b0, STARTADDR};
    localparam logic [32:0] c_last  = {1'b0, STARTADDR} + {1'b0, LENGTH} - 33'd1;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        w_accept;
    logic        w_fault;
    logic [32:0] w_nbytes;
    logic [32:0] w_addr33;
    logic [32:0] w_end33;
    logic [31:0] w_ext;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_fault;
    logic [31:0] r_rdata;

    // 33-bit arithmetic keeps the end-of-range check free of wrap-around.
    always_comb begin
        w_nbytes = 33'd4;
        case (bus.req_size)
            2'b00:   w_nbytes = 33'd1;
            2'b01:   w_nbytes = 33'd2;
            default: w_nbytes = 33'd4;
        endcase
        w_addr33 = {1'b0, bus.req_addr};
        w_end33  = w_addr33 + w_nbytes - 33'd1;
        w_fault  = (bus.req_size == 2'b11)
                 | ((bus.req_size == 2'b01) & bus.req_addr[0])
                 | ((bus.req_size == 2'b10) & (|bus.req_addr[1:0]))
                 | (w_addr33 < c_first)
                 | (w_end33 > c_last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_accept = 1'b1;
                    w_next   = w_fault ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Big-endian: the addressed byte always arrives in the MSB lane.
    always_comb begin
        w_ext = bus.mem_data;
        case (r_size)
            2'b00:   w_ext = {{24{~r_uns & bus.mem_data[31]}}, bus.mem_data[31:24]};
            2'b01:   w_ext = {{16{~r_uns & bus.mem_data[31]}}, bus.mem_data[31:16]};
            default: w_ext = bus.mem_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_fault <= 1'b0;
            r_rdata <= 32'h0;
        end else if (w_accept) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_unsigned;
            r_fault <= w_fault;
            r_rdata <= 32'h0;
            // Faulting requests leave the memory-facing address/data untouched.
            if (!w_fault) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
        end else if ((r_state == S_ACCESS) && !r_we) begin
            r_rdata <= w_ext;
        end
    end

    assign bus.req_ready         = (r_state == S_IDLE);
    assign bus.resp_valid        = (r_state == S_RESP);
    assign bus.resp_fault        = (r_state == S_RESP) & r_fault;
    assign bus.resp_rdata        = (r_state == S_RESP) ? r_rdata : 32'h0;
    assign bus.mem_address       = r_addr;
    assign bus.mem_datain        = r_wdata;
    // Reset gates the strobe directly so a reset during ACCESS commits nothing.
    assign bus.mem_WE            = (r_state == S_ACCESS) & r_we & ~reset;
    assign bus.mem_writebyte     = (r_state == S_ACCESS) & (r_size == 2'b00);
    assign bus.mem_writehalfword = (r_state == S_ACCESS) & (r_size == 2'b01);
endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_ctrl
//  Description : Directed and random load/store traffic against a byte-array
//                memory model and a transaction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;
    localparam logic [31:0] c_start = 32'h1000_0000;
    localparam int          c_len   = 4096;

    logic clk = 1'b0;
    logic reset;
    logic fill;
    int   n_tests = 0;
    int   n_fail  = 0;

    dmem_access_ctrl_if bus ();

    dmem_access_ctrl #(
        .STARTADDR(c_start),
        .LENGTH   (32'h0000_1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Environment memory: big-endian, asynchronous read, write on posedge.
    logic [7:0]  env_mem [c_len];
    logic [32:0] w_off;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    always_comb begin
        w_off        = {1'b0, bus.mem_address} - {1'b0, c_start};
        bus.mem_data = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (w_off + 33'(k) < 33'(c_len))
                bus.mem_data[31 - 8 * k -: 8] = env_mem[w_off + 33'(k)];
        end
    end

    always @(posedge clk) begin : p_mem_wr
        int off;
        off = int'(bus.mem_address - c_start);
        if (fill) begin
            for (int i = 0; i < c_len; i++) env_mem[i] <= init_byte(i);
        end else if (bus.mem_WE) begin
            if (bus.mem_writebyte) begin
                env_mem[off] <= bus.mem_datain[7:0];
            end else if (bus.mem_writehalfword) begin
                env_mem[off]     <= bus.mem_datain[15:8];
                env_mem[off + 1] <= bus.mem_datain[7:0];
            end else begin
                env_mem[off]     <= bus.mem_datain[31:24];
                env_mem[off + 1] <= bus.mem_datain[23:16];
                env_mem[off + 2] <= bus.mem_datain[15:8];
                env_mem[off + 3] <= bus.mem_datain[7:0];
            end
        end
    end

    // Reference: byte image plus the one transaction in flight.
    logic [7:0]  ref_mem [c_len];
    int          stage;
    logic        m_we;
    logic [1:0]  m_size;
    logic        m_uns;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_fault;
    logic [31:0] m_rdata;

    function automatic int size_bytes(logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_fault(logic [1:0] size, logic [31:0] addr);
        longint a;
        longint n;
        a = longint'({32'b0, addr});
        n = longint'(size_bytes(size));
        if (size == 2'b11) return 1'b1;
        if (a % n != 0) return 1'b1;
        if (a < longint'({32'b0, c_start})) return 1'b1;
        if (a + n > longint'({32'b0, c_start}) + longint'(c_len)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [1:0] size, logic uns, logic [31:0] addr);
        int     off;
        int     n;
        longint v;
        off = int'(addr - c_start);
        n   = size_bytes(size);
        v   = 0;
        for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[off + i]);
        if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(logic [1:0] size, logic [31:0] addr, logic [31:0] data);
        int off;
        int n;
        off = int'(addr - c_start);
        n   = size_bytes(size);
        for (int i = 0; i < n; i++) ref_mem[off + i] = 8'((data >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs against the model, drive, advance the model.
    task automatic cycle(input bit v, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        check_val("req_ready",  32'(bus.req_ready),  32'(stage == 0));
        check_val("resp_valid", 32'(bus.resp_valid), 32'(stage == 2));
        check_val("resp_fault", 32'(bus.resp_fault), 32'(stage == 2 && m_fault));
        check_val("resp_rdata", bus.resp_rdata, (stage == 2) ? m_rdata : 32'h0);
        check_val("mem_WE",     32'(bus.mem_WE),     32'(stage == 1 && m_we));
        check_val("mem_wbyte",  32'(bus.mem_writebyte),     32'(stage == 1 && m_size == 2'b00));
        check_val("mem_whalf",  32'(bus.mem_writehalfword), 32'(stage == 1 && m_size == 2'b01));
        if (stage == 1) begin
            check_val("mem_address", bus.mem_address, m_addr);
            if (m_we) check_val("mem_datain", bus.mem_datain, m_wdata);
        end
        bus.req_valid    = v;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge clk);
        case (stage)
            0: if (v) begin
                m_we    = we;
                m_size  = sz;
                m_uns   = uns;
                m_addr  = a;
                m_wdata = wd;
                m_fault = model_fault(sz, a);
                m_rdata = 32'h0;
                stage   = m_fault ? 2 : 1;
            end
            1: begin
                if (m_we) model_store(m_size, m_addr, m_wdata);
                else      m_rdata = model_load(m_size, m_uns, m_addr);
                stage = 2;
            end
            default: stage = 0;
        endcase
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic req(input bit we, input logic [1:0] sz, input bit uns,
                       input logic [31:0] a, input logic [31:0] wd);
        cycle(1'b1, we, sz, uns, a, wd);
        idle(3);
    endtask

    // Load that also checks the response against a fixed expected value.
    task automatic load_expect(input logic [1:0] sz, input bit uns, input logic [31:0] a,
                               input string tag, input logic [31:0] exp);
        cycle(1'b1, 1'b0, sz, uns, a, 32'h0);
        idle(1);
        check_val(tag, bus.resp_rdata, exp);
        idle(2);
    endtask

    task automatic fault_expect(input logic [1:0] sz, input logic [31:0] a, input string tag);
        cycle(1'b1, 1'b1, sz, 1'b0, a, 32'hA5A5_A5A5);
        check_val(tag, {bus.resp_valid, bus.resp_fault, bus.mem_WE}, 32'b110);
        idle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        stage            = 0;
        m_we             = 1'b0;
        m_size           = 2'b00;
        m_uns            = 1'b0;
        m_addr           = 32'h0;
        m_wdata          = 32'h0;
        m_fault          = 1'b0;
        m_rdata          = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        for (int i = 0; i < c_len; i++) ref_mem[i] = init_byte(i);
        reset = 1'b1;
        fill  = 1'b1;
        @(posedge clk);
        #1;
        fill = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outputs",
                  {26'b0, bus.req_ready, bus.resp_valid, bus.resp_fault, bus.mem_WE,
                   bus.mem_writebyte, bus.mem_writehalfword}, 32'b10_0000);
        check_val("rst_rdata",   bus.resp_rdata,  32'h0);
        check_val("rst_address", bus.mem_address, 32'h0);
        check_val("rst_datain",  bus.mem_datain,  32'h0);
        reset = 1'b0;
        idle(1);

        req(1'b1, 2'b10, 1'b0, 32'h1000_0010, 32'hDEAD_BEEF);
        load_expect(2'b10, 1'b0, 32'h1000_0010, "ld_word", 32'hDEAD_BEEF);
        req(1'b1, 2'b00, 1'b0, 32'h1000_0021, 32'h0000_0080);
        load_expect(2'b00, 1'b0, 32'h1000_0021, "ld_byte_s", 32'hFFFF_FF80);
        load_expect(2'b00, 1'b1, 32'h1000_0021, "ld_byte_u", 32'h0000_0080);
        req(1'b1, 2'b01, 1'b0, 32'h1000_0040, 32'h0000_8001);
        load_expect(2'b01, 1'b0, 32'h1000_0040, "ld_half_s", 32'hFFFF_8001);
        load_expect(2'b01, 1'b1, 32'h1000_0040, "ld_half_u", 32'h0000_8001);
        req(1'b0, 2'b10, 1'b0, 32'h1000_0040, 32'h0);

        fault_expect(2'b10, 32'h1000_0002, "flt_word_mis");
        fault_expect(2'b01, 32'h1000_0003, "flt_half_mis");
        fault_expect(2'b11, 32'h1000_0000, "flt_size11");
        fault_expect(2'b10, 32'h1000_1000, "flt_range_hi");
        fault_expect(2'b00, 32'h0FFF_FFFF, "flt_range_lo");
        fault_expect(2'b10, 32'hFFFF_FFFC, "flt_wrap");
        req(1'b1, 2'b10, 1'b0, 32'h1000_0FFC, 32'h1234_5678);
        load_expect(2'b10, 1'b0, 32'h1000_0FFC, "ld_last_word", 32'h1234_5678);

        // Reset during the ACCESS cycle of a store.
        req(1'b1, 2'b10, 1'b0, 32'h1000_0050, 32'h0BAD_F00D);
        cycle(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000_0050, 32'h5555_AAAA);
        bus.req_valid = 1'b0;
        check_val("we_before_rst", 32'(bus.mem_WE), 32'h1);
        reset = 1'b1;
        #1;
        check_val("we_during_rst", 32'(bus.mem_WE), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stage = 0;
        check_val("rst_drop_resp", 32'(bus.resp_valid), 32'h0);
        idle(1);
        load_expect(2'b10, 1'b0, 32'h1000_0050, "rst_readback", 32'h0BAD_F00D);

        // Back-to-back: req_valid held high, new request every cycle.
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom),
                  c_start + 32'(4 * $urandom_range(0, 15)), $urandom);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom % 8)
                0, 1, 2, 3: a = c_start + 32'($urandom % 96);
                4:          a = c_start + 32'(c_len - 8) + 32'($urandom % 16);
                5:          a = c_start - 32'd4 + 32'($urandom % 8);
                6:          a = $urandom;
                default:    a = c_start + 32'($urandom % c_len);
            endcase
            sz = ($urandom % 16 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cycle(($urandom % 10) < 7, 1'($urandom), sz, 1'($urandom), a, $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Initiator-side load/store controller that sits between the CPU datapath and the byte-addressed, big-endian data memory (asynchronous read, write on posedge clk).
- Accepts one load or store request at a time and checks its alignment and address range.
- Drives the memory's address, datain, WE, writebyte and writehalfword inputs.
- Returns sign- or zero-extended load data, or a fault flag, through a one-cycle response pulse.

Parameters:
STARTADDR, 32'h1000_0000, first valid byte address of data memory
LENGTH, 32'h0000_1000, number of bytes in data memory

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  1  request present this cycle
req_ready  output  1  controller can accept a request (IDLE)
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle pulse, request complete
resp_fault  output  1  qualifies resp_valid: misaligned, out of range or illegal size
resp_rdata  output  32  extended load data; 0 for stores and faults
mem_address  output  32  to memory address
mem_datain  output  32  to memory datain
mem_WE  output  1  to memory WE
mem_writebyte  output  1  to memory writebyte
mem_writehalfword  output  1  to memory writehalfword
mem_data  input  32  from memory data, {m[a],m[a+1],m[a+2],m[a+3]}

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_fault 0, resp_rdata 0, mem_address 0, mem_datain 0, mem_WE 0, mem_writebyte 0, mem_writehalfword 0.
- IDLE: req_ready=1. When req_valid=1 at a posedge, capture addr, wdata, we, size and unsigned, then evaluate the fault checks:
  - fault if size==11;
  - fault if half and addr[0]!=0;
  - fault if word and addr[1:0]!=0;
  - fault if addr<STARTADDR or addr+nbytes-1 > STARTADDR+LENGTH-1, with nbytes = 1, 2 or 4 and 33-bit compare so there is no wrap-around.
- On a fault, go directly to RESP with the fault flag set; memory is never touched, so mem_WE stays 0. Otherwise go to ACCESS.
- ACCESS (exactly one cycle), req_ready=0:
  - mem_address = captured addr.
  - mem_datain = captured wdata.
  - mem_writebyte = (size==00); mem_writehalfword = (size==01).
  - mem_WE = we & ~reset, combinational gate, so a reset asserted during ACCESS commits no write.
  - Load: latch mem_data at the end of the cycle.
  - Next state: RESP.
- Load extraction (big-endian, MSB lane):
  - byte: mem_data[31:24] extended to 32 bits;
  - half: mem_data[31:16] extended;
  - word: mem_data unchanged.
  - Extension is sign or zero per req_unsigned; req_unsigned is ignored for word and for stores.
- RESP: resp_valid=1 for exactly one cycle.
  - resp_fault = captured fault flag.
  - resp_rdata = extracted load data; forced to 0 for stores and faults.
  - Next state: IDLE. resp_* return to 0 in IDLE.
- Latency: accept at edge N, ACCESS in cycle N..N+1, resp_valid high in cycle N+1..N+2. A faulting request responds one cycle earlier.
- No response backpressure. Requests arriving while req_ready=0 are ignored, not queued.
- mem_WE, mem_writebyte and mem_writehalfword are 0 outside ACCESS. mem_address and mem_datain hold their last values.
- Reset in any state: next edge forces IDLE with all reset values, and any pending response is dropped.

Test Plan:
- Store word 32'hDEADBEEF at 32'h1000_0010, then load word from the same address -> mem_WE high exactly one cycle; load resp_rdata=32'hDEADBEEF, resp_fault=0, resp_valid two cycles after accept.
- Store byte 8'h80 at 32'h1000_0021, then load byte signed and unsigned from 32'h1000_0021 -> mem_writebyte=1 during the store; resp_rdata=32'hFFFF_FF80 (signed) and 32'h0000_0080 (unsigned).
- Store half 16'h8001 at 32'h1000_0040, then load half signed -> resp_rdata=32'hFFFF_8001; word load at 32'h1000_0040 returns 32'h8001_xxxx, upper half 16'h8001.
- Misaligned word at 32'h1000_0002, half at 32'h1000_0003, size 11 at 32'h1000_0000, and word at 32'h1000_1000 (out of range) -> resp_fault=1, resp_rdata=0, mem_WE never asserted, response one cycle after accept; word at 32'h1000_0FFC accepted with no fault.
- Assert reset in the ACCESS cycle of a store to 32'h1000_0050 -> mem_WE=0 at that edge, memory unchanged on readback, no resp_valid, req_ready=1 the cycle after reset deasserts.
- Hold req_valid high continuously with back-to-back requests -> a new request is accepted only in IDLE, one response per accepted request, intermediate requests ignored.
